// File: rtl/pwm_multi_pkg.sv
// pwm_multi_pkg: shared definitions for the multi-channel PWM slot.
//   Bus geometry, register byte offsets, CTRL bit positions, channel limit,
//   timebase mode and count-direction enums, and an address helper.
package pwm_multi_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAX_CH = 16;

    localparam logic [7:0] ADDR_DVSR      = 8'h00;
    localparam logic [7:0] ADDR_CTRL      = 8'h04;
    localparam logic [7:0] ADDR_POL       = 8'h08;
    localparam logic [7:0] ADDR_STATUS    = 8'h0C;
    localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_CENTER_BIT = 1;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_e;

    // Word index of a byte address (drops the byte-lane bits).
    function automatic logic [5:0] word_of(input logic [7:0] a);
        return a[7:2];
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: MMIO slot bus for the PWM peripheral.
//   master : drives chip_select, read, write, addr, wr_data
//   slave  : returns rd_data, slave_error, decode_error (all combinational)
interface pwm_multi_if;
    import pwm_multi_pkg::*;

    logic              chip_select;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              slave_error;
    logic              decode_error;

    modport master (
        output chip_select, read, write, addr, wr_data,
        input  rd_data, slave_error, decode_error
    );

    modport slave (
        input  chip_select, read, write, addr, wr_data,
        output rd_data, slave_error, decode_error
    );

endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler plus edge/center timebase counter.
//   clk, arst_n : clock, asynchronous active-low reset
//   en          : run enable; when low pcnt/cnt are held at 0, direction up
//   dvsr        : prescaler divisor, tick every dvsr+1 cycles
//   dvsr_wr     : divisor is being written this cycle, restarts pcnt
//   center      : active mode (EDGE sawtooth / CENTER triangle)
//   cnt         : timebase count
//   boundary    : pulse in the tick where cnt moves to 0
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int unsigned RESOLUTION = 10
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  en,
    input  logic [31:0]           dvsr,
    input  logic                  dvsr_wr,
    input  pwm_mode_e             center,
    output logic [RESOLUTION-1:0] cnt,
    output logic                  boundary
);

    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;
    localparam logic [RESOLUTION-1:0] CNT_ONE = RESOLUTION'(1);

    logic [31:0]           pcnt;
    logic [31:0]           pcnt_nxt;
    logic [RESOLUTION-1:0] cnt_nxt;
    cnt_dir_e              dir;
    cnt_dir_e              dir_nxt;
    logic                  tick;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pcnt <= '0;
            cnt  <= '0;
            dir  <= DIR_UP;
        end else begin
            pcnt <= pcnt_nxt;
            cnt  <= cnt_nxt;
            dir  <= dir_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        tick     = en && (pcnt == dvsr);
        pcnt_nxt = pcnt;
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        if (!en) begin
            pcnt_nxt = '0;
            cnt_nxt  = '0;
            dir_nxt  = DIR_UP;
        end else begin
            if (dvsr_wr || tick) begin
                pcnt_nxt = '0;
            end else begin
                pcnt_nxt = pcnt + 32'd1;
            end
            if (tick) begin
                if (center == EDGE) begin
                    cnt_nxt = cnt + CNT_ONE;
                end else if (dir == DIR_UP) begin
                    // Peak is visited once; the down leg starts one below it.
                    if (cnt == CNT_MAX) begin
                        cnt_nxt = CNT_MAX - CNT_ONE;
                        dir_nxt = DIR_DOWN;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        dir_nxt = DIR_UP;
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        boundary = tick && (cnt_nxt == '0);
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: NUM_CH-channel MMIO PWM sharing one prescaler and timebase.
//   clk, arst_n : clock, asynchronous active-low reset
//   bus         : slot bus (slave side) - DVSR, CTRL, POL, STATUS, DUTY[i]
//   pwm_out     : registered PWM outputs, one per channel
// Duty writes land in a shadow register; the active duty reloads from the
// shadow at every period boundary (and continuously while disabled).
module pwm_multi
    import pwm_multi_pkg::*;
#(
    parameter int unsigned RESOLUTION = 10,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    pwm_multi_if.slave        bus,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [5:0] DUTY_WORD = ADDR_DUTY_BASE[7:2];
    localparam logic [5:0] NUM_CH_W  = 6'(NUM_CH);

    logic                  access;
    logic                  aligned;
    logic [5:0]            word;
    logic [5:0]            duty_idx;
    logic                  hit_dvsr;
    logic                  hit_ctrl;
    logic                  hit_pol;
    logic                  hit_status;
    logic                  hit_duty;
    logic                  mapped;
    logic                  dec_err;
    logic                  slv_err;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [31:0]           rd_mux;
    logic [31:0]           rd_data_c;

    logic [31:0]           dvsr;
    logic                  ctrl_en;
    pwm_mode_e             ctrl_mode;
    pwm_mode_e             ctrl_mode_d;
    pwm_mode_e             mode_act;
    logic [NUM_CH-1:0]     pol;
    logic                  period_flag;
    logic [RESOLUTION:0]   duty_shadow [NUM_CH];
    logic [NUM_CH-1:0]     cmp;

    logic [RESOLUTION-1:0] cnt;
    logic                  boundary;

    // Address decode and access qualification
    always_comb begin
        access     = bus.chip_select && (bus.read || bus.write);
        aligned    = (bus.addr[1:0] == 2'b00);
        word       = word_of(bus.addr);
        duty_idx   = word - DUTY_WORD;
        hit_dvsr   = (bus.addr == ADDR_DVSR);
        hit_ctrl   = (bus.addr == ADDR_CTRL);
        hit_pol    = (bus.addr == ADDR_POL);
        hit_status = (bus.addr == ADDR_STATUS);
        hit_duty   = aligned && (word >= DUTY_WORD) && (duty_idx < NUM_CH_W);
        mapped     = hit_dvsr || hit_ctrl || hit_pol || hit_status || hit_duty;
        dec_err    = access && !mapped;
        slv_err    = access && mapped && bus.write && hit_status;
        wr_ok      = bus.chip_select && bus.write && mapped && !hit_status;
        rd_ok      = bus.chip_select && bus.read && mapped && !slv_err;
    end

    // Next value of CTRL.center, so an enable write that also selects the
    // mode starts the timebase in the newly written mode.
    always_comb begin
        ctrl_mode_d = ctrl_mode;
        if (wr_ok && hit_ctrl) begin
            ctrl_mode_d = pwm_mode_e'(bus.wr_data[CTRL_CENTER_BIT]);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            dvsr      <= '0;
            ctrl_en   <= 1'b0;
            ctrl_mode <= EDGE;
            pol       <= '0;
        end else if (wr_ok) begin
            if (hit_dvsr) dvsr <= bus.wr_data;
            if (hit_ctrl) begin
                ctrl_en   <= bus.wr_data[CTRL_EN_BIT];
                ctrl_mode <= ctrl_mode_d;
            end
            if (hit_pol) pol <= bus.wr_data[NUM_CH-1:0];
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_act <= EDGE;
        end else if (!ctrl_en || boundary) begin
            mode_act <= ctrl_mode_d;
        end
    end

    // A boundary in the same cycle as a STATUS read keeps the flag set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            period_flag <= 1'b0;
        end else if (boundary) begin
            period_flag <= 1'b1;
        end else if (rd_ok && hit_status) begin
            period_flag <= 1'b0;
        end
    end

    pwm_timebase #(
        .RESOLUTION(RESOLUTION)
    ) u_timebase (
        .clk     (clk),
        .arst_n  (arst_n),
        .en      (ctrl_en),
        .dvsr    (dvsr),
        .dvsr_wr (wr_ok && hit_dvsr),
        .center  (mode_act),
        .cnt     (cnt),
        .boundary(boundary)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [RESOLUTION:0] shadow;
        logic [RESOLUTION:0] active;
        logic                wr_hit;

        assign wr_hit = wr_ok && hit_duty && (duty_idx == 6'(i));

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                shadow <= '0;
            end else if (wr_hit) begin
                shadow <= bus.wr_data[RESOLUTION:0];
            end
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                active <= '0;
            end else if (!ctrl_en || boundary) begin
                active <= shadow;
            end
        end

        assign duty_shadow[i] = shadow;
        assign cmp[i]         = ({1'b0, cnt} < active);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pwm_out <= '0;
        end else if (!ctrl_en) begin
            pwm_out <= pol;
        end else begin
            pwm_out <= cmp ^ pol;
        end
    end

    // Read mux; data only on a legal read, zero otherwise
    always_comb begin
        rd_mux = '0;
        if (hit_dvsr) rd_mux = dvsr;
        if (hit_ctrl) begin
            rd_mux[CTRL_EN_BIT]     = ctrl_en;
            rd_mux[CTRL_CENTER_BIT] = (ctrl_mode == CENTER);
        end
        if (hit_pol)    rd_mux[NUM_CH-1:0] = pol;
        if (hit_status) rd_mux[0] = period_flag;
        if (hit_duty) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (duty_idx == 6'(i)) rd_mux = 32'(duty_shadow[i]);
            end
        end
        rd_data_c = rd_ok ? rd_mux : '0;
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.slave_error  = slv_err;
    assign bus.decode_error = dec_err;

endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
    import pwm_multi_pkg::*;

    localparam int unsigned RES = 4;
    localparam int unsigned NCH = 4;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic [NCH-1:0] pwm_out;

    pwm_multi_if bus();

    pwm_multi #(
        .RESOLUTION(RES),
        .NUM_CH    (NCH)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.chip_select = 1'b0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.addr        = '0;
        bus.wr_data     = '0;
    endtask

    // Called just after a negedge; occupies exactly one clock cycle.
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d,
                             input logic exp_serr, input logic exp_derr, input string tag);
        bus.chip_select = 1'b1;
        bus.write       = 1'b1;
        bus.addr        = a;
        bus.wr_data     = d;
        #1;
        check_val({tag, "_err"}, {30'b0, bus.slave_error, bus.decode_error}, {30'b0, exp_serr, exp_derr});
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input logic [7:0] a, input logic [31:0] exp_data,
                            input logic exp_serr, input logic exp_derr, input string tag);
        bus.chip_select = 1'b1;
        bus.read        = 1'b1;
        bus.addr        = a;
        #1;
        check_val({tag, "_data"}, bus.rd_data, exp_data);
        check_val({tag, "_err"}, {30'b0, bus.slave_error, bus.decode_error}, {30'b0, exp_serr, exp_derr});
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_write(a, d, 1'b0, 1'b0, "wr");
    endtask

    // Combinational read without any clock edge.
    task automatic peek(input logic [7:0] a, input logic [31:0] exp, input string tag);
        bus.chip_select = 1'b1;
        bus.read        = 1'b1;
        bus.addr        = a;
        #1;
        check_val(tag, bus.rd_data, exp);
        bus_idle();
    endtask

    // Returns at the first negedge where pwm_out[ch] has just risen.
    task automatic wait_rise(input int ch, input string tag);
        logic prev;
        logic seen;
        prev = pwm_out[ch];
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (!prev && pwm_out[ch]) seen = 1'b1;
            prev = pwm_out[ch];
        end
        check_val({tag, "_rise"}, {31'b0, seen}, 32'd1);
    endtask

    // Starting right after a rise: count high clocks, then low clocks,
    // and return right after the following rise.
    task automatic period_chk(input int ch, input int exp_hi, input int exp_lo, input string tag);
        int hi;
        int lo;
        hi = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pwm_out[ch]) hi++;
            else break;
        end
        lo = 1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!pwm_out[ch]) lo++;
            else break;
        end
        check_val({tag, "_hi"}, 32'(hi), 32'(exp_hi));
        check_val({tag, "_lo"}, 32'(lo), 32'(exp_lo));
    endtask

    task automatic count_ones(input int ch, input int n, output int ones);
        ones = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (pwm_out[ch]) ones++;
        end
    endtask

    function automatic logic [7:0] duty_addr(input int i);
        logic [7:0] base;
        base = ADDR_DUTY_BASE;
        return base + 8'(4 * i);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ones0;
        int ones1;

        bus_idle();
        arst_n = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // Reset values
        check_val("rst_pwm", 32'(pwm_out), 32'd0);
        bus_read(ADDR_DVSR,   32'd0, 1'b0, 1'b0, "rst_dvsr");
        bus_read(ADDR_CTRL,   32'd0, 1'b0, 1'b0, "rst_ctrl");
        bus_read(ADDR_POL,    32'd0, 1'b0, 1'b0, "rst_pol");
        bus_read(ADDR_STATUS, 32'd0, 1'b0, 1'b0, "rst_status");
        bus_read(duty_addr(0), 32'd0, 1'b0, 1'b0, "rst_duty0");

        // Register read-back and field widths
        wr(ADDR_DVSR, 32'hA5A5_0003);
        bus_read(ADDR_DVSR, 32'hA5A5_0003, 1'b0, 1'b0, "rb_dvsr");
        wr(ADDR_CTRL, 32'hFFFF_FFFE);
        bus_read(ADDR_CTRL, 32'h0000_0002, 1'b0, 1'b0, "rb_ctrl");
        wr(ADDR_CTRL, 32'h0);
        wr(ADDR_POL, 32'hFFFF_FFF5);
        bus_read(ADDR_POL, 32'h0000_0005, 1'b0, 1'b0, "rb_pol");
        wr(ADDR_POL, 32'h0);
        repeat (2) @(negedge clk);
        wr(duty_addr(2), 32'hFFFF_FFFF);
        bus_read(duty_addr(2), 32'h0000_001F, 1'b0, 1'b0, "rb_duty2");
        wr(duty_addr(2), 32'h0);

        // Edge mode, DVSR=0, DUTY0=4: 4 high / 12 low
        wr(ADDR_DVSR, 32'd0);
        wr(duty_addr(0), 32'd4);
        wr(ADDR_CTRL, 32'd1);
        wait_rise(0, "edge");
        period_chk(0, 4, 12, "edge");

        // Just after a rise: boundary B was two posedges ago.
        bus_read(ADDR_STATUS, 32'd1, 1'b0, 1'b0, "flag_set");
        bus_read(ADDR_STATUS, 32'd0, 1'b0, 1'b0, "flag_clr");
        repeat (12) @(negedge clk);
        // This read is sampled on the next boundary edge.
        bus_read(ADDR_STATUS, 32'd0, 1'b0, 1'b0, "flag_pre_bnd");
        bus_read(ADDR_STATUS, 32'd1, 1'b0, 1'b0, "flag_set_wins");

        // Error rules
        wait_rise(0, "err_sync");
        bus_write(ADDR_STATUS, 32'h0, 1'b1, 1'b0, "wr_status");
        bus_read(ADDR_STATUS, 32'd1, 1'b0, 1'b0, "flag_after_slverr");
        bus_read(8'h20, 32'd0, 1'b0, 1'b1, "rd_unmapped");
        bus_read(8'h06, 32'd0, 1'b0, 1'b1, "rd_misaligned");
        bus_write(8'h20, 32'h0000_00FF, 1'b0, 1'b1, "wr_unmapped");
        bus_read(duty_addr(3), 32'd0, 1'b0, 1'b0, "rd_duty3");
        bus.read = 1'b1;
        bus.addr = 8'h20;
        #1;
        check_val("no_cs", {bus.rd_data[29:0], bus.slave_error, bus.decode_error}, 32'd0);
        bus_idle();
        @(negedge clk);

        // Duty limits and polarity
        wr(duty_addr(0), 32'd0);
        wr(duty_addr(1), 32'd16);
        repeat (20) @(negedge clk);
        count_ones(0, 32, ones0);
        check_val("duty0_zero", 32'(ones0), 32'd0);
        count_ones(1, 32, ones1);
        check_val("duty1_full", 32'(ones1), 32'd32);
        wr(ADDR_POL, 32'h3);
        repeat (2) @(negedge clk);
        count_ones(0, 32, ones0);
        check_val("pol_duty0", 32'(ones0), 32'd32);
        count_ones(1, 32, ones1);
        check_val("pol_duty1", 32'(ones1), 32'd0);
        wr(ADDR_POL, 32'h0);
        repeat (2) @(negedge clk);

        // Shadow update mid-period
        wr(duty_addr(0), 32'd4);
        wait_rise(0, "shadow");
        repeat (5) @(negedge clk);
        wr(duty_addr(0), 32'd12);
        bus_read(duty_addr(0), 32'd12, 1'b0, 1'b0, "shadow_rb");
        check_val("shadow_old_duty", {31'b0, pwm_out[0]}, 32'd0);
        wait_rise(0, "shadow_new");
        period_chk(0, 12, 4, "shadow_new");

        // Center mode, DVSR=1, DUTY0=4: first partial high 8, then 14 / 46
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_DVSR, 32'd1);
        wr(duty_addr(0), 32'd4);
        wr(ADDR_CTRL, 32'd3);
        wait_rise(0, "center");
        period_chk(0, 8, 46, "center_first");
        period_chk(0, 14, 46, "center");

        // Reset mid-period while channel 1 is high
        wr(ADDR_CTRL, 32'd0);
        wr(ADDR_CTRL, 32'd1);
        repeat (4) @(negedge clk);
        check_val("pre_rst_pwm1", {31'b0, pwm_out[1]}, 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check_val("rst_async_pwm", 32'(pwm_out), 32'd0);
        peek(ADDR_DVSR,    32'd0, "rst_async_dvsr");
        peek(ADDR_CTRL,    32'd0, "rst_async_ctrl");
        peek(duty_addr(1), 32'd0, "rst_async_duty1");
        @(negedge clk);
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("post_rst_pwm", 32'(pwm_out), 32'd0);
        bus_read(ADDR_CTRL, 32'd0, 1'b0, 1'b0, "post_rst_ctrl");
        bus_read(ADDR_STATUS, 32'd0, 1'b0, 1'b0, "post_rst_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
